// File: rtl/ultrasonic_ping_scheduler.sv
// Round-robin ultrasonic ranging scheduler.
// One shared echo-timing engine is time-multiplexed across N_SENSORS sensors:
// trigger the selected sensor, time its echo pulse, report the width (or a
// timeout), wait out a holdoff so stray bursts die down, then move on to the
// next enabled sensor.
module ultrasonic_ping_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int IDX_W          = 2,
  parameter int CNT_W          = 24,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int HOLDOFF_CYCLES = 3000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_sensor,
  output logic                 result_valid,
  output logic [IDX_W-1:0]     result_sensor,
  output logic [CNT_W-1:0]     result_width,
  output logic                 result_timeout
);

  // Wide enough to hold (last + offset) before the modulo fold.
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  state_t state_reg, state_next;

  // Echo synchronizer and edge-detect history, one bit per sensor.
  logic [N_SENSORS-1:0] echo_meta_reg;
  logic [N_SENSORS-1:0] echo_sync_reg;
  logic [N_SENSORS-1:0] echo_prev_reg;

  // Sequencing counters and rotation state.
  logic [CNT_W-1:0] phase_cnt_reg;   // TRIG high time and HOLDOFF length
  logic [CNT_W-1:0] tmo_cnt_reg;     // cycles since trigger fall
  logic [CNT_W-1:0] width_reg;       // synchronized echo high time
  logic [IDX_W-1:0] last_reg;        // last sensor pinged (rotation pointer)
  logic [IDX_W-1:0] cur_sensor_reg;

  // Result holding registers.
  logic             result_valid_reg;
  logic [IDX_W-1:0] result_sensor_reg;
  logic [CNT_W-1:0] result_width_reg;
  logic             result_timeout_reg;

  // Next-sensor candidate table: candidate gi is (last + gi + 1) mod N.
  logic [IDX_W-1:0]     cand_idx [N_SENSORS];
  logic [N_SENSORS-1:0] cand_en;
  logic [IDX_W-1:0]     sel_idx;

  // Decoded conditions.
  logic sel_sync;
  logic sel_prev;
  logic rise_det;
  logic fall_det;
  logic tmo_hit;
  logic trig_done;
  logic hold_done;
  logic can_start;
  logic load_sel;
  logic emit_normal;
  logic emit_tmo;

  generate
    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_cand
      logic [SUM_W-1:0] cand_sum;
      assign cand_sum     = SUM_W'(last_reg) + SUM_W'(gi + 1);
      assign cand_idx[gi] = (cand_sum >= SUM_W'(N_SENSORS))
                          ? IDX_W'(cand_sum - SUM_W'(N_SENSORS))
                          : IDX_W'(cand_sum);
      assign cand_en[gi]  = sensor_mask[cand_idx[gi]];
    end
  endgenerate

  // Pick the enabled candidate closest after the last pinged sensor.
  always_comb begin
    sel_idx = last_reg;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (cand_en[i]) begin
        sel_idx = cand_idx[i];
      end
    end
  end

  // Only the selected sensor's synchronized echo drives the engine.
  assign sel_sync  = echo_sync_reg[cur_sensor_reg];
  assign sel_prev  = echo_prev_reg[cur_sensor_reg];
  assign rise_det  = sel_sync & ~sel_prev;
  assign fall_det  = ~sel_sync & sel_prev;
  assign tmo_hit   = (tmo_cnt_reg >= CNT_W'(TIMEOUT_CYCLES));
  assign trig_done = (phase_cnt_reg == CNT_W'(TRIG_CYCLES - 1));
  assign hold_done = (phase_cnt_reg == CNT_W'(HOLDOFF_CYCLES - 1));
  assign can_start = enable && (sensor_mask != '0);

  // A detected edge wins over a timeout landing on the same cycle.
  assign emit_normal = (state_reg == S_MEASURE) && fall_det;
  assign emit_tmo    = ((state_reg == S_WAIT_RISE) && !rise_det && tmo_hit) ||
                       ((state_reg == S_MEASURE)   && !fall_det && tmo_hit);
  assign load_sel    = can_start &&
                       ((state_reg == S_IDLE) ||
                        ((state_reg == S_HOLDOFF) && hold_done));

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta_reg <= '0;
      echo_sync_reg <= '0;
      echo_prev_reg <= '0;
    end else begin
      echo_meta_reg <= echo;
      echo_sync_reg <= echo_meta_reg;
      echo_prev_reg <= echo_sync_reg;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (can_start) state_next = S_TRIG;
      end
      S_TRIG: begin
        if (trig_done) state_next = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (rise_det)     state_next = S_MEASURE;
        else if (tmo_hit) state_next = S_HOLDOFF;
      end
      S_MEASURE: begin
        if (fall_det || tmo_hit) state_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (hold_done) state_next = can_start ? S_TRIG : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs: one trigger bit while in TRIG, busy outside IDLE.
  always_comb begin
    trig = '0;
    busy = (state_reg != S_IDLE);
    if (state_reg == S_TRIG) begin
      trig[cur_sensor_reg] = 1'b1;
    end
  end

  // Phase counter restarts on every state change; it times TRIG and HOLDOFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      phase_cnt_reg <= '0;
    end else if ((state_reg == S_TRIG) || (state_reg == S_HOLDOFF)) begin
      phase_cnt_reg <= phase_cnt_reg + 1'b1;
    end
  end

  // Timeout timer runs from trigger fall through WAIT_RISE and MEASURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == S_TRIG) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == S_WAIT_RISE) || (state_reg == S_MEASURE)) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Width counter: loads 1 on the rise so the rise cycle itself is counted,
  // then saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_reg <= '0;
    end else if ((state_reg == S_WAIT_RISE) && rise_det) begin
      width_reg <= CNT_W'(1);
    end else if ((state_reg == S_MEASURE) && (width_reg != '1)) begin
      width_reg <= width_reg + 1'b1;
    end
  end

  // Rotation pointer starts at the top index so the first ping scans from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg       <= IDX_W'(N_SENSORS - 1);
      cur_sensor_reg <= '0;
    end else if (load_sel) begin
      last_reg       <= sel_idx;
      cur_sensor_reg <= sel_idx;
    end
  end

  // Result registers: one-cycle valid pulse, data held between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid_reg   <= 1'b0;
      result_sensor_reg  <= '0;
      result_width_reg   <= '0;
      result_timeout_reg <= 1'b0;
    end else begin
      result_valid_reg <= emit_normal || emit_tmo;
      if (emit_normal) begin
        result_sensor_reg  <= cur_sensor_reg;
        result_width_reg   <= width_reg;
        result_timeout_reg <= 1'b0;
      end else if (emit_tmo) begin
        result_sensor_reg  <= cur_sensor_reg;
        result_width_reg   <= '1;
        result_timeout_reg <= 1'b1;
      end
    end
  end

  assign cur_sensor     = cur_sensor_reg;
  assign result_valid   = result_valid_reg;
  assign result_sensor  = result_sensor_reg;
  assign result_width   = result_width_reg;
  assign result_timeout = result_timeout_reg;

endmodule

// File: tb/tb_ultrasonic_ping_scheduler.sv
// Directed bench for ultrasonic_ping_scheduler with N=4, TRIG=4, TIMEOUT=100,
// HOLDOFF=20. A behavioural sensor model answers each trigger fall; a monitor
// logs trigger starts/lengths and results for the scenario tasks to check.
module tb_ultrasonic_ping_scheduler;

  localparam int N = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 24;
  localparam int M_PULSE = 0, M_LOW = 1, M_STICK = 2, M_TOGGLE = 3;
  localparam int ECHO_DLY = 10, ECHO_WID = 30, STICK_DLY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [N-1:0] sensor_mask = '0;
  logic [N-1:0] echo = '0;
  logic [N-1:0] trig;
  logic busy;
  logic [IDX_W-1:0] cur_sensor;
  logic result_valid;
  logic [IDX_W-1:0] result_sensor;
  logic [CNT_W-1:0] result_width;
  logic result_timeout;

  int compare_cnt = 0;
  int mismatch_cnt = 0;
  int cyc = 0;

  ultrasonic_ping_scheduler #(
    .N_SENSORS(N), .IDX_W(IDX_W), .CNT_W(CNT_W),
    .TRIG_CYCLES(4), .TIMEOUT_CYCLES(100), .HOLDOFF_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor_mask(sensor_mask),
    .echo(echo), .trig(trig), .busy(busy), .cur_sensor(cur_sensor),
    .result_valid(result_valid), .result_sensor(result_sensor),
    .result_width(result_width), .result_timeout(result_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model state
  int mode [N];
  bit act [N];
  int rcnt [N];
  bit stuck [N];
  logic [N-1:0] rtrig_prev = '0;

  // Monitor logs
  int st_sensor[$], st_cycle[$], tlen_q[$], fall_cycle[$];
  int res_sensor[$], res_width[$], res_timeout[$], res_cycle[$];
  int overlap_cnt = 0, dbl_cnt = 0, tlen = 0;
  logic [N-1:0] mtrig_prev = '0;
  logic mvalid_prev = 1'b0;

  // Sensor model: reacts to its own trigger fall, drives echo at negedges.
  initial begin
    for (int i = 0; i < N; i++) begin
      mode[i] = M_PULSE; act[i] = 0; rcnt[i] = 0; stuck[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rtrig_prev[i] && !trig[i]) begin
          act[i] = 1; rcnt[i] = 0;
        end else if (act[i]) begin
          rcnt[i]++;
        end
        case (mode[i])
          M_PULSE:  echo[i] = act[i] && rcnt[i] >= ECHO_DLY && rcnt[i] < ECHO_DLY + ECHO_WID;
          M_LOW:    echo[i] = 1'b0;
          M_STICK:  begin
                      if (act[i] && rcnt[i] == STICK_DLY) stuck[i] = 1;
                      echo[i] = stuck[i];
                    end
          default:  echo[i] = cyc[2];
        endcase
        rtrig_prev[i] = trig[i];
      end
    end
  end

  // Monitor: logs trigger starts/falls/lengths and results at negedges.
  initial begin
    forever begin
      @(negedge clk);
      if ($countones(trig) > 1) overlap_cnt++;
      if (trig != '0 && mtrig_prev == '0) begin
        for (int i = 0; i < N; i++) if (trig[i]) st_sensor.push_back(i);
        st_cycle.push_back(cyc);
      end
      if (trig != '0) tlen++;
      if (trig == '0 && mtrig_prev != '0) begin
        tlen_q.push_back(tlen); fall_cycle.push_back(cyc); tlen = 0;
      end
      if (result_valid) begin
        res_sensor.push_back(int'(result_sensor));
        res_width.push_back(int'(result_width));
        res_timeout.push_back(int'(result_timeout));
        res_cycle.push_back(cyc);
        if (mvalid_prev) dbl_cnt++;
      end
      mvalid_prev = result_valid;
      mtrig_prev = trig;
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    st_sensor.delete(); st_cycle.delete(); tlen_q.delete(); fall_cycle.delete();
    res_sensor.delete(); res_width.delete(); res_timeout.delete(); res_cycle.delete();
    overlap_cnt = 0; dbl_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      mode[i] = M_PULSE; act[i] = 0; stuck[i] = 0;
    end
    tick(); tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_starts(input int n, input int budget, input string what);
    int k = 0;
    while (st_sensor.size() < n && k < budget) begin tick(); k++; end
    compare_cnt++;
    if (st_sensor.size() < n) begin
      mismatch_cnt++;
      $display("FAIL %s: saw %0d trigger starts, required %0d", what, st_sensor.size(), n);
    end
  endtask

  task automatic wait_results(input int n, input int budget, input string what);
    int k = 0;
    while (res_sensor.size() < n && k < budget) begin tick(); k++; end
    compare_cnt++;
    if (res_sensor.size() < n) begin
      mismatch_cnt++;
      $display("FAIL %s: saw %0d results, required %0d", what, res_sensor.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string what, output int idle_cyc);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(); k++; end
    idle_cyc = cyc;
    compare_cnt++;
    if (busy !== 1'b0) begin
      mismatch_cnt++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", what, busy, budget);
    end
  endtask

  task automatic test_reset();
    int exp_zero = 0;
    enable = 1'b1; sensor_mask = 4'b1111; rst = 1'b1;
    tick(); tick(); tick();
    compare_cnt += 7;
    if (trig !== 4'b0000) begin mismatch_cnt++; $display("FAIL reset_trig: got %b need 0000", trig); end
    if (busy !== 1'b0) begin mismatch_cnt++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (cur_sensor !== 2'd0) begin mismatch_cnt++; $display("FAIL reset_cur: got %0d need 0", cur_sensor); end
    if (result_valid !== 1'b0) begin mismatch_cnt++; $display("FAIL reset_valid: got %b need 0", result_valid); end
    if (result_sensor !== 2'd0) begin mismatch_cnt++; $display("FAIL reset_rsensor: got %0d need 0", result_sensor); end
    if (int'(result_width) !== exp_zero) begin mismatch_cnt++; $display("FAIL reset_width: got %0d need 0", result_width); end
    if (result_timeout !== 1'b0) begin mismatch_cnt++; $display("FAIL reset_timeout: got %b need 0", result_timeout); end
    // Released but disabled, then enabled with an empty mask: stays idle.
    rst = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    compare_cnt++;
    if (busy !== 1'b0) begin mismatch_cnt++; $display("FAIL idle_disabled: busy %b need 0", busy); end
    enable = 1'b1; sensor_mask = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    compare_cnt++;
    if (busy !== 1'b0) begin mismatch_cnt++; $display("FAIL idle_empty_mask: busy %b need 0", busy); end
    enable = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int idle_cyc;
    do_reset();
    sensor_mask = 4'b1111; enable = 1'b1;
    wait_starts(5, 2000, "rr_starts");
    enable = 1'b0;
    wait_idle(500, "rr_idle", idle_cyc);
    for (int i = 0; i < 5; i++) begin
      compare_cnt += 2;
      if (qget(st_sensor, i) !== exp_order[i]) begin mismatch_cnt++;
        $display("FAIL rr_order[%0d]: got %0d need %0d", i, qget(st_sensor, i), exp_order[i]); end
      if (qget(tlen_q, i) !== 4) begin mismatch_cnt++;
        $display("FAIL rr_trig_len[%0d]: got %0d need 4", i, qget(tlen_q, i)); end
    end
    for (int i = 0; i < 4; i++) begin
      compare_cnt += 3;
      if (qget(res_sensor, i) !== i) begin mismatch_cnt++;
        $display("FAIL rr_res_sensor[%0d]: got %0d need %0d", i, qget(res_sensor, i), i); end
      if (qget(res_width, i) !== 30) begin mismatch_cnt++;
        $display("FAIL rr_res_width[%0d]: got %0d need 30", i, qget(res_width, i)); end
      if (qget(res_timeout, i) !== 0) begin mismatch_cnt++;
        $display("FAIL rr_res_timeout[%0d]: got %0d need 0", i, qget(res_timeout, i)); end
    end
    compare_cnt += 4;
    if (qget(st_cycle, 1) - qget(st_cycle, 0) !== 67) begin mismatch_cnt++;
      $display("FAIL rr_period: got %0d need 67", qget(st_cycle, 1) - qget(st_cycle, 0)); end
    if (qget(res_cycle, 0) - qget(st_cycle, 0) !== 47) begin mismatch_cnt++;
      $display("FAIL rr_result_latency: got %0d need 47", qget(res_cycle, 0) - qget(st_cycle, 0)); end
    if (overlap_cnt !== 0) begin mismatch_cnt++; $display("FAIL rr_overlap: got %0d need 0", overlap_cnt); end
    if (dbl_cnt !== 0) begin mismatch_cnt++; $display("FAIL rr_valid_width: got %0d need 0", dbl_cnt); end
    $display("test_round_robin done: %0d pings, %0d results", st_sensor.size(), res_sensor.size());
  endtask

  task automatic test_mask_0101();
    int exp_order [4] = '{0, 2, 0, 2};
    int idle_cyc;
    do_reset();
    mode[1] = M_TOGGLE; mode[3] = M_TOGGLE;
    sensor_mask = 4'b0101; enable = 1'b1;
    wait_starts(4, 1500, "mask_starts");
    enable = 1'b0;
    wait_idle(500, "mask_idle", idle_cyc);
    for (int i = 0; i < 4; i++) begin
      compare_cnt += 3;
      if (qget(st_sensor, i) !== exp_order[i]) begin mismatch_cnt++;
        $display("FAIL mask_order[%0d]: got %0d need %0d", i, qget(st_sensor, i), exp_order[i]); end
      if (qget(res_sensor, i) !== exp_order[i]) begin mismatch_cnt++;
        $display("FAIL mask_res_sensor[%0d]: got %0d need %0d", i, qget(res_sensor, i), exp_order[i]); end
      if (qget(res_width, i) !== 30) begin mismatch_cnt++;
        $display("FAIL mask_res_width[%0d]: got %0d need 30", i, qget(res_width, i)); end
    end
    compare_cnt++;
    if (st_sensor.size() !== 4) begin mismatch_cnt++;
      $display("FAIL mask_ping_count: got %0d need 4", st_sensor.size()); end
    $display("test_mask_0101 done: %0d pings", st_sensor.size());
  endtask

  task automatic test_timeout_low();
    int idle_cyc;
    do_reset();
    mode[1] = M_LOW;
    sensor_mask = 4'b0110; enable = 1'b1;
    wait_starts(2, 1000, "tlow_starts");
    enable = 1'b0;
    wait_idle(500, "tlow_idle", idle_cyc);
    compare_cnt += 7;
    if (qget(st_sensor, 0) !== 1) begin mismatch_cnt++; $display("FAIL tlow_first: got %0d need 1", qget(st_sensor, 0)); end
    if (qget(st_sensor, 1) !== 2) begin mismatch_cnt++; $display("FAIL tlow_next: got %0d need 2", qget(st_sensor, 1)); end
    if (qget(res_sensor, 0) !== 1) begin mismatch_cnt++; $display("FAIL tlow_res_sensor: got %0d need 1", qget(res_sensor, 0)); end
    if (qget(res_timeout, 0) !== 1) begin mismatch_cnt++; $display("FAIL tlow_timeout: got %0d need 1", qget(res_timeout, 0)); end
    if (qget(res_width, 0) !== 32'h00FF_FFFF) begin mismatch_cnt++;
      $display("FAIL tlow_width: got %0h need ffffff", qget(res_width, 0)); end
    if (qget(res_cycle, 0) - qget(fall_cycle, 0) !== 101) begin mismatch_cnt++;
      $display("FAIL tlow_latency: got %0d need 101", qget(res_cycle, 0) - qget(fall_cycle, 0)); end
    if (qget(st_cycle, 1) - qget(res_cycle, 0) !== 20) begin mismatch_cnt++;
      $display("FAIL tlow_holdoff: got %0d need 20", qget(st_cycle, 1) - qget(res_cycle, 0)); end
    $display("test_timeout_low done");
  endtask

  task automatic test_stuck_high();
    int idle_cyc;
    do_reset();
    mode[0] = M_STICK;
    sensor_mask = 4'b0001; enable = 1'b1;
    wait_results(2, 800, "stuck_results");
    enable = 1'b0;
    wait_idle(500, "stuck_idle", idle_cyc);
    for (int i = 0; i < 2; i++) begin
      compare_cnt += 4;
      if (qget(res_sensor, i) !== 0) begin mismatch_cnt++;
        $display("FAIL stuck_sensor[%0d]: got %0d need 0", i, qget(res_sensor, i)); end
      if (qget(res_timeout, i) !== 1) begin mismatch_cnt++;
        $display("FAIL stuck_timeout[%0d]: got %0d need 1", i, qget(res_timeout, i)); end
      if (qget(res_width, i) !== 32'h00FF_FFFF) begin mismatch_cnt++;
        $display("FAIL stuck_width[%0d]: got %0h need ffffff", i, qget(res_width, i)); end
      if (qget(res_cycle, i) - qget(fall_cycle, i) !== 101) begin mismatch_cnt++;
        $display("FAIL stuck_latency[%0d]: got %0d need 101", i, qget(res_cycle, i) - qget(fall_cycle, i)); end
    end
    mode[0] = M_PULSE; stuck[0] = 0;
    $display("test_stuck_high done");
  endtask

  task automatic test_reset_mid_measure();
    do_reset();
    sensor_mask = 4'b1111; enable = 1'b1;
    wait_starts(2, 500, "rmid_starts");
    for (int i = 0; i < 29; i++) tick();
    rst = 1'b1;
    tick();
    compare_cnt += 6;
    if (trig !== 4'b0000) begin mismatch_cnt++; $display("FAIL rmid_trig: got %b need 0000", trig); end
    if (busy !== 1'b0) begin mismatch_cnt++; $display("FAIL rmid_busy: got %b need 0", busy); end
    if (cur_sensor !== 2'd0) begin mismatch_cnt++; $display("FAIL rmid_cur: got %0d need 0", cur_sensor); end
    if (result_valid !== 1'b0) begin mismatch_cnt++; $display("FAIL rmid_valid: got %b need 0", result_valid); end
    if (result_sensor !== 2'd0) begin mismatch_cnt++; $display("FAIL rmid_rsensor: got %0d need 0", result_sensor); end
    if (result_width !== 24'd0) begin mismatch_cnt++; $display("FAIL rmid_width: got %0d need 0", result_width); end
    clear_log();
    rst = 1'b0;
    wait_results(1, 300, "rmid_results");
    compare_cnt += 4;
    if (qget(st_sensor, 0) !== 0) begin mismatch_cnt++; $display("FAIL rmid_restart: got %0d need 0", qget(st_sensor, 0)); end
    if (qget(res_sensor, 0) !== 0) begin mismatch_cnt++; $display("FAIL rmid_res_sensor: got %0d need 0", qget(res_sensor, 0)); end
    if (qget(res_width, 0) !== 30) begin mismatch_cnt++; $display("FAIL rmid_res_width: got %0d need 30", qget(res_width, 0)); end
    if (qget(res_cycle, 0) - qget(st_cycle, 0) !== 47) begin mismatch_cnt++;
      $display("FAIL rmid_res_time: got %0d need 47", qget(res_cycle, 0) - qget(st_cycle, 0)); end
    enable = 1'b0;
    $display("test_reset_mid_measure done");
  endtask

  task automatic test_enable_drop();
    int idle_cyc;
    do_reset();
    sensor_mask = 4'b1111; enable = 1'b1;
    wait_starts(3, 1000, "edrop_starts");
    enable = 1'b0;
    wait_idle(500, "edrop_idle", idle_cyc);
    compare_cnt += 5;
    if (st_sensor.size() !== 3) begin mismatch_cnt++; $display("FAIL edrop_ping_count: got %0d need 3", st_sensor.size()); end
    if (res_sensor.size() !== 3) begin mismatch_cnt++; $display("FAIL edrop_res_count: got %0d need 3", res_sensor.size()); end
    if (qget(res_sensor, 2) !== 2) begin mismatch_cnt++; $display("FAIL edrop_res_sensor: got %0d need 2", qget(res_sensor, 2)); end
    if (qget(res_width, 2) !== 30) begin mismatch_cnt++; $display("FAIL edrop_res_width: got %0d need 30", qget(res_width, 2)); end
    if (idle_cyc - qget(res_cycle, 2) !== 20) begin mismatch_cnt++;
      $display("FAIL edrop_holdoff: got %0d need 20", idle_cyc - qget(res_cycle, 2)); end
    enable = 1'b1;
    wait_starts(4, 100, "edrop_resume");
    compare_cnt++;
    if (qget(st_sensor, 3) !== 3) begin mismatch_cnt++; $display("FAIL edrop_resume_sensor: got %0d need 3", qget(st_sensor, 3)); end
    enable = 1'b0;
    $display("test_enable_drop done");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask_0101();
    test_timeout_low();
    test_stuck_high();
    test_reset_mid_measure();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
